// File: rtl/seg7_serial_driver.sv
// Serial 7-segment chain driver: decodes an 8-digit hex word and shifts 64 active-low segment bits
// MSB-first into a 74HC595-style chain, then latches. Optional blinking is enabled by SEG7_BLINK_EN.
module seg7_serial_driver #(
  parameter int unsigned CLK_DIV        = 2,
  parameter int unsigned REFRESH_PERIOD = 1000000
`ifdef SEG7_BLINK_EN
  ,
  parameter int unsigned BLINK_PERIOD   = 25000000
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] disp_num,
  input  logic [7:0]  point_n,
  input  logic [7:0]  digit_en,
`ifdef SEG7_BLINK_EN
  input  logic [7:0]  blink_mask,
`endif
  output logic        seg_clk,
  output logic        seg_dout,
  output logic        seg_latch,
  output logic        seg_clr_n,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH} state_t;

  localparam int unsigned RW       = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
`ifdef SEG7_BLINK_EN
  localparam int unsigned BW       = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
  localparam int unsigned SNAP_W   = 56;
`else
  localparam int unsigned SNAP_W   = 48;
`endif

  function automatic logic [6:0] seg7_lut(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  state_t             state_q, state_d;
  logic [7:0]         div_q, div_d;
  logic [5:0]         bit_q, bit_d;
  logic [63:0]        frame_q, frame_d;
  logic [SNAP_W-1:0]  snap_q, snap_d;
  logic               pending_q, pending_d;
  logic [RW-1:0]      refresh_cnt_q, refresh_cnt_d;
  logic               seg_clk_q, seg_clk_d;
  logic               seg_dout_q, seg_dout_d;
  logic               seg_latch_q, seg_latch_d;
  logic               seg_clr_n_q, seg_clr_n_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;

  logic               refresh_hit;
  logic               blink_hit;
  logic [7:0]         blank;
  logic [SNAP_W-1:0]  snap_in;
  logic [63:0]        frame_in;
  logic               div_last;

  assign refresh_hit   = (refresh_cnt_q == RW'(REFRESH_PERIOD - 1));
  assign refresh_cnt_d = refresh_hit ? '0 : refresh_cnt_q + RW'(1);

`ifdef SEG7_BLINK_EN
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;

  assign blink_hit     = (blink_cnt_q == BW'(BLINK_PERIOD - 1));
  assign blink_cnt_d   = blink_hit ? '0 : blink_cnt_q + BW'(1);
  assign blink_phase_d = blink_phase_q ^ blink_hit;
  // Use the upcoming phase so a frame started by the toggle already shows the new phase.
  assign blank         = ~digit_en | (blink_phase_d ? blink_mask : 8'h00);
  assign snap_in       = {disp_num, point_n, digit_en, blink_mask};

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end
`else
  assign blink_hit = 1'b0;
  assign blank     = ~digit_en;
  assign snap_in   = {disp_num, point_n, digit_en};
`endif

  for (genvar gi = 0; gi < 8; gi++) begin : g_digit
    assign frame_in[gi*8 +: 8] = blank[gi] ? 8'hFF : {point_n[gi], seg7_lut(disp_num[gi*4 +: 4])};
  end

  assign div_last = (div_q == DIV_LAST);

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    bit_d        = bit_q;
    frame_d      = frame_q;
    snap_d       = snap_q;
    pending_d    = pending_q | refresh_hit | blink_hit;
    seg_clk_d    = seg_clk_q;
    seg_dout_d   = seg_dout_q;
    seg_latch_d  = seg_latch_q;
    seg_clr_n_d  = 1'b1;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        // A refresh expiring on the very cycle a frame starts is absorbed by that frame.
        if (pending_q || refresh_hit || blink_hit || (snap_in != snap_q)) begin
          state_d   = LOAD;
          snap_d    = snap_in;
          frame_d   = frame_in;
          pending_d = 1'b0;
          busy_d    = 1'b1;
        end
      end
      LOAD: begin
        state_d    = SHIFT_LO;
        bit_d      = 6'd63;
        div_d      = 8'd0;
        seg_clk_d  = 1'b0;
        seg_dout_d = frame_q[63];
      end
      SHIFT_LO: begin
        if (div_last) begin
          state_d   = SHIFT_HI;
          div_d     = 8'd0;
          seg_clk_d = 1'b1;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      SHIFT_HI: begin
        if (div_last) begin
          div_d     = 8'd0;
          seg_clk_d = 1'b0;
          if (bit_q == 6'd0) begin
            state_d     = LATCH;
            seg_latch_d = 1'b1;
          end else begin
            state_d    = SHIFT_LO;
            bit_d      = bit_q - 6'd1;
            seg_dout_d = frame_q[bit_q - 6'd1];
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      LATCH: begin
        if (div_last) begin
          state_d      = IDLE;
          div_d        = 8'd0;
          seg_latch_d  = 1'b0;
          frame_done_d = 1'b1;
          busy_d       = 1'b0;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      div_q         <= 8'd0;
      bit_q         <= 6'd0;
      frame_q       <= '0;
      snap_q        <= '0;
      pending_q     <= 1'b1;
      refresh_cnt_q <= '0;
      seg_clk_q     <= 1'b0;
      seg_dout_q    <= 1'b0;
      seg_latch_q   <= 1'b0;
      seg_clr_n_q   <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      bit_q         <= bit_d;
      frame_q       <= frame_d;
      snap_q        <= snap_d;
      pending_q     <= pending_d;
      refresh_cnt_q <= refresh_cnt_d;
      seg_clk_q     <= seg_clk_d;
      seg_dout_q    <= seg_dout_d;
      seg_latch_q   <= seg_latch_d;
      seg_clr_n_q   <= seg_clr_n_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign seg_clk    = seg_clk_q;
  assign seg_dout   = seg_dout_q;
  assign seg_latch  = seg_latch_q;
  assign seg_clr_n  = seg_clr_n_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
